mmio_master: RTL

MMIO_MASTER -- requirements
Module: mmio_master

---
 rtl/mmio_master.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mmio_master.sv
// Single-outstanding MMIO bus master: accepts one load/store, drives a registered
// strobe until the responder completes or the timeout expires, then holds the response.
module mmio_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_misalign,
   output logic        mmio_read,
   output logic        mmio_write,
   output logic [31:0] mmio_addr,
   output logic [31:0] mmio_write_data,
   input  logic        mmio_done,
   input  logic [31:0] mmio_read_data,
   output logic        busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mis_d   = mis_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_addr[1:0] == 2'b00) begin
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
                  rd_d    = ~req_write;
                  wr_d    = req_write;
                  cnt_d   = 16'd0;
                  state_d = ACCESS;
               end else begin
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
                  mis_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ACCESS: begin
            // done beats a simultaneous timeout
            if (mmio_done) begin
               rdata_d = rd_q ? mmio_read_data : 32'd0;
               err_d   = 1'b0;
               mis_d   = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = 32'd0;
               err_d   = 1'b1;
               mis_d   = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RESP;
            end else if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         cnt_q   <= 16'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
      end
   end

   assign req_ready       = (state_q == IDLE);
   assign resp_valid      = (state_q == RESP);
   assign busy            = (state_q != IDLE);
   assign mmio_read       = rd_q;
   assign mmio_write      = wr_q;
   assign mmio_addr       = addr_q;
   assign mmio_write_data = wdata_q;
   assign resp_rdata      = rdata_q;
   assign resp_err        = err_q;
   assign resp_misalign   = mis_q;

endmodule
